// File: rtl/serial_fsm_pkg.sv
// Shared types and defaults for the serial bit source feeding the sequence detectors.
package serial_fsm_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    localparam int SER_WIDTH_DEFAULT = 8;

endpackage : serial_fsm_pkg

// File: rtl/serial_bit_source_fsm.sv
// Parallel-to-serial stage: accepts WIDTH-bit words on valid/ready and emits
// them MSB-first one bit per clock, gapless between back-to-back words.
module serial_bit_source_fsm
    import serial_fsm_pkg::*;
#(
    parameter int   WIDTH    = SER_WIDTH_DEFAULT,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             abort,
    output logic             a,
    output logic             a_valid,
    output logic             word_start
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    ser_state_t       state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             a_q, a_d;
    logic             a_valid_q, a_valid_d;
    logic             word_start_q, word_start_d;

    logic             last_bit;
    logic             transfer;

    // The last bit of a word is on the line when the counter reaches WIDTH-1;
    // that is also the slot where the next word may be loaded without a gap.
    assign last_bit = (state_q == SHIFT) && (cnt_q == CNT_LAST);
    assign in_ready = rst && !abort && ((state_q == IDLE) || last_bit);
    assign transfer = in_valid && in_ready;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state: abort dominates, a transfer always lands in SHIFT,
    // finishing a word without a successor returns to IDLE.
    always_comb begin
        state_d = state_q;
        if (abort)                 state_d = IDLE;
        else if (transfer)         state_d = SHIFT;
        else if (last_bit)         state_d = IDLE;
    end

    // Datapath / output next values; transfer already excludes abort via in_ready.
    always_comb begin
        sr_d         = sr_q;
        cnt_d        = cnt_q;
        a_d          = IDLE_BIT;
        a_valid_d    = 1'b0;
        word_start_d = 1'b0;
        if (abort) begin
            cnt_d = '0;
        end else if (transfer) begin
            a_d          = in_data[WIDTH-1];
            a_valid_d    = 1'b1;
            word_start_d = 1'b1;
            sr_d         = in_data << 1;
            cnt_d        = '0;
        end else if (state_q == SHIFT && !last_bit) begin
            a_d       = sr_q[WIDTH-1];
            a_valid_d = 1'b1;
            sr_d      = sr_q << 1;
            cnt_d     = cnt_q + CNT_W'(1);
        end else if (last_bit) begin
            cnt_d = '0;
        end
    end

    // Shift register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sr_q <= '0;
        else      sr_q <= sr_d;
    end

    // Bit counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    // Registered serial outputs toward the detector
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q          <= IDLE_BIT;
            a_valid_q    <= 1'b0;
            word_start_q <= 1'b0;
        end else begin
            a_q          <= a_d;
            a_valid_q    <= a_valid_d;
            word_start_q <= word_start_d;
        end
    end

    assign a          = a_q;
    assign a_valid    = a_valid_q;
    assign word_start = word_start_q;

endmodule : serial_bit_source_fsm
